fp_addsub_seq: RTL and testbench

- Multi-cycle, parametrised IEEE-754-style floating-point adder/subtractor with a start/done handshake and an internal FSM.
- Generalises the combinational sum datapath:
  - runtime add/sub op select;
  - full alignment with guard/round/sticky bits;
  - iterative leading-zero normalisation;
  - round-to-nearest-even;
  - special-value handling and exception flags.
- Sits between the operand register file and the FPU result bus.

---
 rtl/fp_addsub_seq.sv | 195 +++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with a start/done handshake.
// Operands pass through ALIGN, ADD, NORM (iterative) and ROUND before DONE.
module fp_addsub_seq #(
   parameter int N_float = 32,
   parameter int N_exp   = 8,
   parameter int N_mant  = 23
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               op,
   input  logic [N_float-1:0] float_A,
   input  logic [N_float-1:0] float_B,
   output logic               busy,
   output logic               done,
   output logic [N_float-1:0] float_R,
   output logic [3:0]         flags
);

   // Working field layout: {hidden, mantissa, guard, round, sticky}
   localparam int W = N_mant + 4;
   localparam logic [N_exp-1:0] EXP_ONES = '1;
   localparam logic [N_exp-1:0] EXP_ONE  = N_exp'(1);
   localparam logic [N_exp-1:0] W_E      = N_exp'(W);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM, ST_ROUND, ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [N_float-1:0]   a_q, a_d, b_q, b_d;
   logic [N_float-1:0]   float_r_q, float_r_d;
   logic [3:0]           flags_q, flags_d;
   logic                 sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic [N_exp-1:0]     exp_q, exp_d;
   logic [W:0]           work_q, work_d;
   logic [W-1:0]         s_q, s_d;

   logic                 a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [N_exp-1:0]     a_exp, b_exp;
   logic [N_mant-1:0]    a_man, b_man;
   logic [W-1:0]         a_field, b_field;

   assign a_sign  = a_q[N_float-1];
   assign b_sign  = b_q[N_float-1];
   assign a_exp   = a_q[N_float-2 -: N_exp];
   assign b_exp   = b_q[N_float-2 -: N_exp];
   assign a_man   = a_q[N_mant-1:0];
   assign b_man   = b_q[N_mant-1:0];
   assign a_zero  = (a_exp == '0);
   assign b_zero  = (b_exp == '0);
   assign a_inf   = (a_exp == EXP_ONES) && (a_man == '0);
   assign b_inf   = (b_exp == EXP_ONES) && (b_man == '0);
   assign a_nan   = (a_exp == EXP_ONES) && (a_man != '0);
   assign b_nan   = (b_exp == EXP_ONES) && (b_man != '0);
   assign a_field = a_zero ? '0 : {1'b1, a_man, 3'b000};
   assign b_field = b_zero ? '0 : {1'b1, b_man, 3'b000};

   logic                 a_is_l, l_sign;
   logic [N_exp-1:0]     l_exp, s_exp, diff, shamt;
   logic [W-1:0]         l_field, s_field, s_aligned;
   logic [2*W-1:0]       wide;

   // Zeros carry a zero field, so a plain {exp, field} compare orders magnitudes.
   assign a_is_l    = {a_exp, a_field} >= {b_exp, b_field};
   assign l_sign    = a_is_l ? a_sign  : b_sign;
   assign l_exp     = a_is_l ? a_exp   : b_exp;
   assign s_exp     = a_is_l ? b_exp   : a_exp;
   assign l_field   = a_is_l ? a_field : b_field;
   assign s_field   = a_is_l ? b_field : a_field;
   assign diff      = l_exp - s_exp;
   assign shamt     = (diff > W_E) ? W_E : diff;
   assign wide      = {s_field, {W{1'b0}}} >> shamt;
   assign s_aligned = wide[2*W-1:W] | {{(W-1){1'b0}}, |wide[W-1:0]};

   logic                 rnd_inc, rnd_inexact;
   logic [N_mant+1:0]    man_r;
   logic [N_exp:0]       exp_r;
   logic [N_mant-1:0]    man_fin;

   assign rnd_inc     = work_q[2] & (work_q[1] | work_q[0] | work_q[3]);
   assign rnd_inexact = work_q[2] | work_q[1] | work_q[0];
   assign man_r       = {1'b0, work_q[W-1:3]} + {{(N_mant+1){1'b0}}, rnd_inc};
   assign exp_r       = {1'b0, exp_q} + {{N_exp{1'b0}}, man_r[N_mant+1]};
   assign man_fin     = man_r[N_mant+1] ? man_r[N_mant:1] : man_r[N_mant-1:0];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      float_r_d = float_r_q;
      flags_d   = flags_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      work_d    = work_q;
      s_d       = s_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = float_A;
               b_d     = {float_B[N_float-1] ^ op, float_B[N_float-2:0]};
               state_d = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
               float_r_d = {1'b0, EXP_ONES, 1'b1, {(N_mant-1){1'b0}}};
               flags_d   = 4'b1000;
               state_d   = ST_DONE;
            end else if (a_inf || b_inf) begin
               float_r_d = a_inf ? a_q : b_q;
               flags_d   = 4'b0000;
               state_d   = ST_DONE;
            end else begin
               sign_d    = l_sign;
               eff_sub_d = a_sign ^ b_sign;
               exp_d     = l_exp;
               work_d    = {1'b0, l_field};
               s_d       = s_aligned;
               state_d   = ST_ADD;
            end
         end
         ST_ADD: begin
            work_d  = eff_sub_q ? (work_q - {1'b0, s_q}) : (work_q + {1'b0, s_q});
            state_d = ST_NORM;
         end
         ST_NORM: begin
            if (work_q[W]) begin
               work_d  = {1'b0, work_q[W:2], work_q[1] | work_q[0]};
               exp_d   = exp_q + EXP_ONE;
               state_d = ST_ROUND;
            end else if (work_q == '0) begin
               // Only two -0 operands (an effective add) keep the negative sign.
               float_r_d = {eff_sub_q ? 1'b0 : sign_q, {(N_float-1){1'b0}}};
               flags_d   = 4'b0000;
               state_d   = ST_DONE;
            end else if (work_q[W-1]) begin
               state_d = ST_ROUND;
            end else if (exp_q == EXP_ONE) begin
               float_r_d = {sign_q, {(N_float-1){1'b0}}};
               flags_d   = 4'b0011;
               state_d   = ST_DONE;
            end else begin
               work_d = {work_q[W-1:0], 1'b0};
               exp_d  = exp_q - EXP_ONE;
            end
         end
         ST_ROUND: begin
            if (exp_r >= {1'b0, EXP_ONES}) begin
               float_r_d = {sign_q, EXP_ONES, {N_mant{1'b0}}};
               flags_d   = 4'b0101;
            end else begin
               float_r_d = {sign_q, exp_r[N_exp-1:0], man_fin};
               flags_d   = {3'b000, rnd_inexact};
            end
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         float_r_q <= '0;
         flags_q   <= '0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         work_q    <= '0;
         s_q       <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         float_r_q <= float_r_d;
         flags_q   <= flags_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         work_q    <= work_d;
         s_q       <= s_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign float_R = float_r_q;
   assign flags   = flags_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: expected results are queued when an
// operation is issued and popped when the DUT raises done.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        op;
   logic [31:0] float_A, float_B;
   logic        busy, done;
   logic [31:0] float_R;
   logic [3:0]  flags;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        o;
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   exp_t sb[$];

   fp_addsub_seq #(.N_float(32), .N_exp(8), .N_mant(23)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .float_A (float_A),
      .float_B (float_B),
      .busy    (busy),
      .done    (done),
      .float_R (float_R),
      .flags   (flags)
   );

   always #5 clk = ~clk;

   // Drives one request and observes the DUT; judging is left to the callers.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                         output logic [31:0] r, output logic [3:0] f, output int lat,
                         output bit busy_ok, output bit tail_ok, output bit to);
      busy_ok = 1'b1;
      tail_ok = 1'b0;
      to      = 1'b0;
      r       = '0;
      f       = '0;
      @(negedge clk);
      float_A = a;
      float_B = b;
      op      = o;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 60) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1 lat++;
      end
      if (!done) begin
         to = 1'b1;
      end else begin
         if (!busy) busy_ok = 1'b0;
         r = float_R;
         f = flags;
         @(posedge clk);
         #1 tail_ok = !done && !busy;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      op = 1'b0;
      float_A = '0;
      float_B = '0;
      #3;
      n_cmp++;
      if ({busy, done, float_R, flags} !== 38'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b R=%h flags=%b, want all zero",
                  busy, done, float_R, flags);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_arith();
      vec_t v[$];
      logic [31:0] r; logic [3:0] f; int lat; bit bok, tok, to; exp_t e;
      v.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5});
      v.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 5});
      v.push_back('{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, 4});
      v.push_back('{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 5});
      v.push_back('{32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000, 4'b0000, 5});
      v.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 4});
      foreach (v[i]) begin
         sb.push_back('{v[i].r, v[i].f, v[i].lat});
         run_op(v[i].a, v[i].b, v[i].o, r, f, lat, bok, tok, to);
         e = sb.pop_front();
         n_cmp++;
         if (to) begin
            n_bad++;
            $display("FAIL arith[%0d] timeout: no done within 60 cycles", i);
         end else begin
            if ({r, f} !== {e.r, e.f}) begin
               n_bad++;
               $display("FAIL arith[%0d] result: got R=%h flags=%b, want R=%h flags=%b",
                        i, r, f, e.r, e.f);
            end
            n_cmp++;
            if (lat != e.lat) begin
               n_bad++;
               $display("FAIL arith[%0d] latency: got %0d, want %0d", i, lat, e.lat);
            end
            n_cmp++;
            if (!bok || !tok) begin
               n_bad++;
               $display("FAIL arith[%0d] handshake: busy_ok=%b tail_ok=%b, want 1 1", i, bok, tok);
            end
         end
      end
   endtask

   task automatic test_rounding();
      vec_t v[$];
      logic [31:0] r; logic [3:0] f; int lat; bit bok, tok, to; exp_t e;
      v.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5});
      v.push_back('{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 5});
      v.push_back('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 28});
      foreach (v[i]) begin
         sb.push_back('{v[i].r, v[i].f, v[i].lat});
         run_op(v[i].a, v[i].b, v[i].o, r, f, lat, bok, tok, to);
         e = sb.pop_front();
         n_cmp++;
         if (to) begin
            n_bad++;
            $display("FAIL round[%0d] timeout: no done within 60 cycles", i);
         end else begin
            if ({r, f} !== {e.r, e.f}) begin
               n_bad++;
               $display("FAIL round[%0d] result: got R=%h flags=%b, want R=%h flags=%b",
                        i, r, f, e.r, e.f);
            end
            n_cmp++;
            if (lat != e.lat) begin
               n_bad++;
               $display("FAIL round[%0d] latency: got %0d, want %0d", i, lat, e.lat);
            end
         end
      end
   endtask

   task automatic test_special();
      vec_t v[$];
      logic [31:0] r; logic [3:0] f; int lat; bit bok, tok, to; exp_t e;
      v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5});
      v.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2});
      v.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2});
      v.push_back('{32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'b0000, 2});
      v.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 2});
      foreach (v[i]) begin
         sb.push_back('{v[i].r, v[i].f, v[i].lat});
         run_op(v[i].a, v[i].b, v[i].o, r, f, lat, bok, tok, to);
         e = sb.pop_front();
         n_cmp++;
         if (to) begin
            n_bad++;
            $display("FAIL special[%0d] timeout: no done within 60 cycles", i);
         end else begin
            if ({r, f} !== {e.r, e.f}) begin
               n_bad++;
               $display("FAIL special[%0d] result: got R=%h flags=%b, want R=%h flags=%b",
                        i, r, f, e.r, e.f);
            end
            n_cmp++;
            if (lat != e.lat) begin
               n_bad++;
               $display("FAIL special[%0d] latency: got %0d, want %0d", i, lat, e.lat);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0;
      int lat = 0;
      logic [31:0] r = '0;
      logic [3:0]  f = '0;
      exp_t e;
      sb.push_back('{32'h34000000, 4'b0000, 28});
      @(negedge clk);
      float_A = 32'h3F800001;
      float_B = 32'h3F800000;
      op      = 1'b1;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         if (k == 6) begin
            float_A = 32'h3F800000;
            float_B = 32'h3F800000;
            op      = 1'b0;
            start   = 1'b1;
         end
         if (k == 7) start = 1'b0;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               lat = k;
               r = float_R;
               f = flags;
            end
         end
         @(posedge clk);
         #1;
      end
      e = sb.pop_front();
      n_cmp++;
      if (ndone != 1) begin
         n_bad++;
         $display("FAIL start_ignored count: got %0d done pulses, want 1", ndone);
      end
      n_cmp++;
      if ({r, f} !== {e.r, e.f} || lat != e.lat) begin
         n_bad++;
         $display("FAIL start_ignored result: got R=%h flags=%b lat=%0d, want R=%h flags=%b lat=%0d",
                  r, f, lat, e.r, e.f, e.lat);
      end
   endtask

   task automatic test_reset_midop();
      int ndone = 0;
      @(negedge clk);
      float_A = 32'h3F800001;
      float_B = 32'h3F800000;
      op      = 1'b1;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, float_R, flags} !== 38'd0) begin
         n_bad++;
         $display("FAIL reset_midop outputs: got busy=%b done=%b R=%h flags=%b, want all zero",
                  busy, done, float_R, flags);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      n_cmp++;
      if (ndone != 0) begin
         n_bad++;
         $display("FAIL reset_midop no_done: got %0d done pulses, want 0", ndone);
      end
   endtask

   task automatic test_after_reset();
      logic [31:0] r; logic [3:0] f; int lat; bit bok, tok, to; exp_t e;
      sb.push_back('{32'h40000000, 4'b0000, 5});
      run_op(32'h3F800000, 32'h3F800000, 1'b0, r, f, lat, bok, tok, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || {r, f} !== {e.r, e.f} || lat != e.lat) begin
         n_bad++;
         $display("FAIL after_reset result: got R=%h flags=%b lat=%0d timeout=%b, want R=%h flags=%b lat=%0d",
                  r, f, lat, to, e.r, e.f, e.lat);
      end
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if ({float_R, flags} !== {e.r, e.f}) begin
         n_bad++;
         $display("FAIL after_reset hold: got R=%h flags=%b, want R=%h flags=%b",
                  float_R, flags, e.r, e.f);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_rounding();
      test_special();
      test_start_ignored();
      test_reset_midop();
      test_after_reset();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
